// File: rtl/ax_btb_banked_queue_if.sv
// Update bundle from IntEx into the approximate-BCC branch target buffer.
// The buffer side raises wrStall when it cannot take more updates.
interface ax_btb_banked_queue_if #(
    parameter int WRITE_NUM = 2
);
    logic [WRITE_NUM-1:0]    wrValid;
    logic [WRITE_NUM*32-1:0] wrPC;
    logic [WRITE_NUM*32-1:0] wrTarget;
    logic [WRITE_NUM-1:0]    wrIsCondBr;
    logic                    wrStall;

    modport master (output wrValid, wrPC, wrTarget, wrIsCondBr, input wrStall);
    modport slave  (input wrValid, wrPC, wrTarget, wrIsCondBr, output wrStall);
endinterface

// File: rtl/ax_btb_banked_queue.sv
// Banked direct-mapped BTB for approximate begin-cycle-count branches, with a
// conflict queue for same-bank updates and an init/flush sweep.
module ax_btb_banked_queue #(
    parameter int ENTRY_NUM    = 512,
    parameter int BANK_NUM     = 4,
    parameter int READ_NUM     = 4,
    parameter int WRITE_NUM    = 2,
    parameter int QUEUE_DEPTH  = 4,
    parameter int TAG_WIDTH    = 8,
    parameter int TARGET_WIDTH = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [31:0]                      rdPC,
    output logic [READ_NUM-1:0]              rdHit,
    output logic [READ_NUM*32-1:0]           rdTarget,
    output logic [READ_NUM-1:0]              rdIsCondBr,
    ax_btb_banked_queue_if.slave             wr,
    output logic                             ready,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] queueCount
);
    localparam int IDX   = $clog2(ENTRY_NUM);
    localparam int ROWS  = ENTRY_NUM / BANK_NUM;
    localparam int ROWW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int EW    = 1 + TAG_WIDTH + TARGET_WIDTH + 1;
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int QC_W  = $clog2(QUEUE_DEPTH + 1);
    localparam logic [QC_W-1:0] ONE = QC_W'(1);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state, stateNext;
    logic [ROWW-1:0]   initCnt, initCntNext;
    logic [EW-1:0]     mem [ENTRY_NUM];
    logic [IDX-1:0]    qIdx [QUEUE_DEPTH];
    logic [EW-1:0]     qData [QUEUE_DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [QC_W-1:0]   count;

    logic [IDX-1:0]    wIdx [WRITE_NUM];
    logic [EW-1:0]     wData [WRITE_NUM];
    logic [PTR_W-1:0]  pushSlot [WRITE_NUM];
    logic [31:0]       lanePC [READ_NUM];
    logic [EW-1:0]     laneEntry [READ_NUM];
    logic [READ_NUM-1:0]  laneHit;
    logic [WRITE_NUM-1:0] accept, direct, divert, popEn;
    logic [QC_W-1:0]   numPush, numPop, numDirect, idle;
    logic              runActive, stallInt, conflict, blocked, draining;
    logic              unusedLane, unusedBus;

    function automatic logic [IDX-1:0] bankOf(input logic [IDX-1:0] i);
        return i & IDX'(BANK_NUM - 1);
    endfunction

    function automatic logic [PTR_W-1:0] wrapAdd(input logic [PTR_W-1:0] ptr, input int n);
        return PTR_W'((int'(ptr) + n) % QUEUE_DEPTH);
    endfunction

    assign ready      = (state == RUN);
    assign stallInt   = (state == INIT) || (count > QC_W'(QUEUE_DEPTH - WRITE_NUM));
    assign wr.wrStall = stallInt;
    assign queueCount = count;
    assign runActive  = (state == RUN) && !rst && !flush;
    assign accept     = wr.wrValid & {WRITE_NUM{runActive && !stallInt}};
    assign unusedBus  = ^{wr.wrPC, wr.wrTarget};

    // State register; the sweep counter restarts on every reset or flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            initCnt <= '0;
        end else begin
            state   <= stateNext;
            initCnt <= initCntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        initCntNext = initCnt;
        if (flush) begin
            stateNext   = INIT;
            initCntNext = '0;
        end else if (state == INIT) begin
            initCntNext = initCnt + ROWW'(1);
            if (initCnt == ROWW'(ROWS - 1)) stateNext = RUN;
        end
    end

    // Field extraction for update ports and the read lanes.
    always_comb begin
        unusedLane = 1'b0;
        for (int p = 0; p < WRITE_NUM; p++) begin
            wIdx[p]  = wr.wrPC[p*32+2 +: IDX];
            wData[p] = {1'b1, wr.wrPC[p*32+IDX+2 +: TAG_WIDTH],
                        wr.wrTarget[p*32+2 +: TARGET_WIDTH], wr.wrIsCondBr[p]};
        end
        for (int l = 0; l < READ_NUM; l++) begin
            lanePC[l]    = rdPC + 32'(4 * l);
            laneEntry[l] = mem[lanePC[l][IDX+1:2]];
            laneHit[l]   = ready && laneEntry[l][EW-1] &&
                           (laneEntry[l][EW-2 -: TAG_WIDTH] == lanePC[l][IDX+2 +: TAG_WIDTH]);
            unusedLane   = unusedLane ^ (^lanePC[l][1:0]);
        end
    end

    // Port arbitration, then in-order drain of the queue into leftover ports.
    always_comb begin
        direct    = '0;
        divert    = '0;
        popEn     = '0;
        numPush   = '0;
        numPop    = '0;
        numDirect = '0;
        conflict  = 1'b0;
        blocked   = 1'b0;
        draining  = 1'b1;
        for (int p = 0; p < WRITE_NUM; p++) begin
            pushSlot[p] = wrapAdd(tail, int'(numPush));
            conflict = 1'b0;
            for (int q = 0; q < WRITE_NUM; q++) begin
                if (q < p && direct[q] && bankOf(wIdx[q]) == bankOf(wIdx[p])) conflict = 1'b1;
                if (q < p && divert[q] && wIdx[q] == wIdx[p]) conflict = 1'b1;
            end
            for (int e = 0; e < QUEUE_DEPTH; e++) begin
                if (QC_W'(e) < count && qIdx[wrapAdd(head, e)] == wIdx[p]) conflict = 1'b1;
            end
            if (accept[p]) begin
                direct[p] = !conflict;
                divert[p] = conflict;
                if (conflict) numPush = numPush + ONE;
                else          numDirect = numDirect + ONE;
            end
        end
        idle = QC_W'(WRITE_NUM) - numDirect;
        for (int k = 0; k < WRITE_NUM; k++) begin
            blocked = !runActive || !(QC_W'(k) < count) || (numPop >= idle);
            for (int p = 0; p < WRITE_NUM; p++) begin
                if (direct[p] && bankOf(wIdx[p]) == bankOf(qIdx[wrapAdd(head, k)])) blocked = 1'b1;
            end
            for (int j = 0; j < WRITE_NUM; j++) begin
                if (j < k && popEn[j] &&
                    bankOf(qIdx[wrapAdd(head, j)]) == bankOf(qIdx[wrapAdd(head, k)])) blocked = 1'b1;
            end
            if (draining && !blocked) begin
                popEn[k] = 1'b1;
                numPop   = numPop + ONE;
            end else begin
                draining = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= wrapAdd(head, int'(numPop));
            tail  <= wrapAdd(tail, int'(numPush));
            count <= count + numPush - numPop;
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < WRITE_NUM; p++) begin
            if (divert[p]) begin
                qIdx[pushSlot[p]]  <= wIdx[p];
                qData[pushSlot[p]] <= wData[p];
            end
        end
    end

    // INIT wipes one row across all banks per cycle; RUN takes direct and drained writes.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            for (int b = 0; b < BANK_NUM; b++) begin
                mem[IDX'(int'(initCnt) * BANK_NUM + b)] <= '0;
            end
        end else begin
            for (int p = 0; p < WRITE_NUM; p++) begin
                if (direct[p]) mem[wIdx[p]] <= wData[p];
            end
            for (int k = 0; k < WRITE_NUM; k++) begin
                if (popEn[k]) mem[qIdx[wrapAdd(head, k)]] <= qData[wrapAdd(head, k)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdHit      <= '0;
            rdTarget   <= '0;
            rdIsCondBr <= '0;
        end else begin
            for (int l = 0; l < READ_NUM; l++) begin
                rdHit[l]              <= laneHit[l];
                rdTarget[l*32 +: 32]  <= {lanePC[l][31:TARGET_WIDTH+2],
                                          laneEntry[l][TARGET_WIDTH:1], 2'b00};
                rdIsCondBr[l]         <= laneHit[l] && laneEntry[l][0];
            end
        end
    end

    noWriteWhileStalled: assert property (@(posedge clk) disable iff (rst || flush)
        !(state == RUN && stallInt && |wr.wrValid));

endmodule

// File: tb/tb_ax_btb_banked_queue.sv
// Directed self-checking bench for ax_btb_banked_queue: init sweep, hits,
// bank conflicts, ordering, backpressure and flush.
module tb_ax_btb_banked_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] rdPC;
    logic [3:0]  rdHit;
    logic [127:0] rdTarget;
    logic [3:0]  rdIsCondBr;
    logic        ready;
    logic [2:0]  queueCount;
    int          assertCount = 0;
    int          failCount = 0;

    ax_btb_banked_queue_if #(.WRITE_NUM(2)) wrBus ();

    ax_btb_banked_queue dut (
        .clk(clk), .rst(rst), .flush(flush), .rdPC(rdPC),
        .rdHit(rdHit), .rdTarget(rdTarget), .rdIsCondBr(rdIsCondBr),
        .wr(wrBus), .ready(ready), .queueCount(queueCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearWrites();
        wrBus.wrValid    = '0;
        wrBus.wrPC       = '0;
        wrBus.wrTarget   = '0;
        wrBus.wrIsCondBr = '0;
    endtask

    task automatic setWrite(input int p, input logic [31:0] pc, input logic [31:0] tgt, input logic cond);
        wrBus.wrValid[p]         = 1'b1;
        wrBus.wrPC[p*32 +: 32]     = pc;
        wrBus.wrTarget[p*32 +: 32] = tgt;
        wrBus.wrIsCondBr[p]      = cond;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; rdPC = 32'h0; clearWrites();
        tick();
        assertCount++; if (rdHit !== 4'b0) begin failCount++; $display("[TB] FAIL reset_rdHit: got %b want 0000", rdHit); end
        assertCount++; if (rdTarget !== 128'h0) begin failCount++; $display("[TB] FAIL reset_rdTarget: got %h want 0", rdTarget); end
        assertCount++; if (rdIsCondBr !== 4'b0) begin failCount++; $display("[TB] FAIL reset_rdIsCondBr: got %b want 0000", rdIsCondBr); end
        assertCount++; if (ready !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ready: got %b want 0", ready); end
        assertCount++; if (wrBus.wrStall !== 1'b1) begin failCount++; $display("[TB] FAIL reset_wrStall: got %b want 1", wrBus.wrStall); end
        assertCount++; if (queueCount !== 3'd0) begin failCount++; $display("[TB] FAIL reset_queueCount: got %0d want 0", queueCount); end
        rst = 1'b0;
    endtask

    task automatic test_init();
        int bad = 0;
        for (int i = 0; i < 127; i++) begin
            tick();
            if (ready !== 1'b0 || wrBus.wrStall !== 1'b1 || rdHit !== 4'b0) bad++;
        end
        assertCount++; if (bad != 0) begin failCount++; $display("[TB] FAIL init_hold: got %0d bad cycles want 0", bad); end
        tick();
        assertCount++; if (ready !== 1'b1) begin failCount++; $display("[TB] FAIL init_ready: got %b want 1", ready); end
        assertCount++; if (wrBus.wrStall !== 1'b0) begin failCount++; $display("[TB] FAIL init_wrStall: got %b want 0", wrBus.wrStall); end
        rdPC = 32'h1000;
        tick();
        assertCount++; if (rdHit !== 4'b0) begin failCount++; $display("[TB] FAIL init_miss: got %b want 0000", rdHit); end
    endtask

    task automatic test_basic_hit();
        setWrite(0, 32'h1000, 32'h1040, 1'b1);
        tick();
        clearWrites();
        assertCount++; if (queueCount !== 3'd0) begin failCount++; $display("[TB] FAIL basic_count: got %0d want 0", queueCount); end
        rdPC = 32'h1000;
        tick();
        assertCount++; if (rdHit !== 4'b0001) begin failCount++; $display("[TB] FAIL basic_hit: got %b want 0001", rdHit); end
        assertCount++; if (rdTarget[31:0] !== 32'h1040) begin failCount++; $display("[TB] FAIL basic_target: got %h want 00001040", rdTarget[31:0]); end
        assertCount++; if (rdIsCondBr !== 4'b0001) begin failCount++; $display("[TB] FAIL basic_cond: got %b want 0001", rdIsCondBr); end
        rdPC = 32'h3000;
        tick();
        assertCount++; if (rdHit[0] !== 1'b0) begin failCount++; $display("[TB] FAIL basic_tag_miss: got %b want 0", rdHit[0]); end
    endtask

    task automatic test_bank_conflict();
        setWrite(0, 32'h1000, 32'h1080, 1'b0);
        setWrite(1, 32'h1010, 32'h10C0, 1'b1);
        tick();
        clearWrites();
        assertCount++; if (queueCount !== 3'd1) begin failCount++; $display("[TB] FAIL conflict_push: got %0d want 1", queueCount); end
        tick();
        assertCount++; if (queueCount !== 3'd0) begin failCount++; $display("[TB] FAIL conflict_drain: got %0d want 0", queueCount); end
        rdPC = 32'h1000;
        tick();
        assertCount++; if (rdHit[0] !== 1'b1 || rdTarget[31:0] !== 32'h1080 || rdIsCondBr[0] !== 1'b0) begin failCount++; $display("[TB] FAIL conflict_read0: got hit %b tgt %h cond %b want 1 00001080 0", rdHit[0], rdTarget[31:0], rdIsCondBr[0]); end
        rdPC = 32'h1010;
        tick();
        assertCount++; if (rdHit[0] !== 1'b1 || rdTarget[31:0] !== 32'h10C0 || rdIsCondBr[0] !== 1'b1) begin failCount++; $display("[TB] FAIL conflict_read1: got hit %b tgt %h cond %b want 1 000010c0 1", rdHit[0], rdTarget[31:0], rdIsCondBr[0]); end
    endtask

    task automatic test_ordering();
        setWrite(0, 32'h1000, 32'h1100, 1'b0);
        setWrite(1, 32'h1010, 32'h2000, 1'b0);
        tick();
        clearWrites();
        assertCount++; if (queueCount !== 3'd1) begin failCount++; $display("[TB] FAIL order_first_queued: got %0d want 1", queueCount); end
        setWrite(0, 32'h1010, 32'h3000, 1'b0);
        tick();
        clearWrites();
        assertCount++; if (queueCount !== 3'd1) begin failCount++; $display("[TB] FAIL order_second_queued: got %0d want 1", queueCount); end
        tick();
        assertCount++; if (queueCount !== 3'd0) begin failCount++; $display("[TB] FAIL order_drain: got %0d want 0", queueCount); end
        rdPC = 32'h1010;
        tick();
        assertCount++; if (rdHit[0] !== 1'b1 || rdTarget[31:0] !== 32'h3000) begin failCount++; $display("[TB] FAIL order_final: got hit %b tgt %h want 1 00003000", rdHit[0], rdTarget[31:0]); end
        setWrite(0, 32'h1200, 32'h1300, 1'b0);
        setWrite(1, 32'h1200, 32'h1400, 1'b0);
        tick();
        clearWrites();
        assertCount++; if (queueCount !== 3'd1) begin failCount++; $display("[TB] FAIL same_index_push: got %0d want 1", queueCount); end
        tick();
        rdPC = 32'h1200;
        tick();
        assertCount++; if (rdHit[0] !== 1'b1 || rdTarget[31:0] !== 32'h1400) begin failCount++; $display("[TB] FAIL same_index_winner: got hit %b tgt %h want 1 00001400", rdHit[0], rdTarget[31:0]); end
    endtask

    task automatic test_backpressure();
        logic [31:0] pcA [3] = '{32'h1100, 32'h1120, 32'h1140};
        logic [31:0] pcB [3] = '{32'h1110, 32'h1130, 32'h1150};
        logic [31:0] pcs [6] = '{32'h1100, 32'h1110, 32'h1120, 32'h1130, 32'h1140, 32'h1150};
        for (int i = 0; i < 3; i++) begin
            assertCount++; if (wrBus.wrStall !== 1'b0) begin failCount++; $display("[TB] FAIL bp_no_stall_%0d: got %b want 0", i, wrBus.wrStall); end
            setWrite(0, pcA[i], pcA[i] + 32'h100, 1'b0);
            setWrite(1, pcB[i], pcB[i] + 32'h100, 1'b1);
            tick();
            clearWrites();
            assertCount++; if (queueCount !== 3'(i + 1)) begin failCount++; $display("[TB] FAIL bp_climb_%0d: got %0d want %0d", i, queueCount, i + 1); end
        end
        assertCount++; if (wrBus.wrStall !== 1'b1) begin failCount++; $display("[TB] FAIL bp_stall: got %b want 1", wrBus.wrStall); end
        for (int i = 2; i >= 0; i--) begin
            tick();
            assertCount++; if (queueCount !== 3'(i)) begin failCount++; $display("[TB] FAIL bp_drain_%0d: got %0d want %0d", i, queueCount, i); end
        end
        for (int i = 0; i < 6; i++) begin
            rdPC = pcs[i];
            tick();
            assertCount++; if (rdHit[0] !== 1'b1 || rdTarget[31:0] !== pcs[i] + 32'h100) begin failCount++; $display("[TB] FAIL bp_read_%0d: got hit %b tgt %h want 1 %h", i, rdHit[0], rdTarget[31:0], pcs[i] + 32'h100); end
        end
    endtask

    task automatic test_flush();
        int bad = 0;
        logic [31:0] oldPcs [4] = '{32'h1000, 32'h1010, 32'h1100, 32'h1400};
        setWrite(0, 32'h1400, 32'h1500, 1'b0);
        setWrite(1, 32'h1410, 32'h1510, 1'b0);
        tick();
        setWrite(0, 32'h1420, 32'h1520, 1'b0);
        setWrite(1, 32'h1430, 32'h1530, 1'b0);
        tick();
        clearWrites();
        assertCount++; if (queueCount !== 3'd2) begin failCount++; $display("[TB] FAIL flush_setup: got %0d want 2", queueCount); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        assertCount++; if (queueCount !== 3'd0 || ready !== 1'b0 || wrBus.wrStall !== 1'b1) begin failCount++; $display("[TB] FAIL flush_entry: got count %0d ready %b stall %b want 0 0 1", queueCount, ready, wrBus.wrStall); end
        for (int i = 0; i < 49; i++) begin
            tick();
            if (ready !== 1'b0) bad++;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 127; i++) begin
            tick();
            if (ready !== 1'b0 || wrBus.wrStall !== 1'b1) bad++;
        end
        assertCount++; if (bad != 0) begin failCount++; $display("[TB] FAIL flush_restart_hold: got %0d bad cycles want 0", bad); end
        tick();
        assertCount++; if (ready !== 1'b1) begin failCount++; $display("[TB] FAIL flush_ready: got %b want 1", ready); end
        for (int i = 0; i < 4; i++) begin
            rdPC = oldPcs[i];
            tick();
            assertCount++; if (rdHit !== 4'b0) begin failCount++; $display("[TB] FAIL flush_miss_%0d: got %b want 0000", i, rdHit); end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_basic_hit();
        test_bank_conflict();
        test_ordering();
        test_backpressure();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/ax_btb_banked_queue.md
Name: ax_btb_banked_queue

Overview:
- Parametrised successor to the approximate-BCC branch target buffer used by the fetch unit for approximate begin-cycle-count branches.
- Direct-mapped, multi-bank storage with READ_NUM fetch lanes and WRITE_NUM update ports from IntEx.
- A configurable-depth conflict queue accepts multiple pushes per cycle and drains multiple entries per cycle, with index-ordering guarantees.
- Adds an explicit init/flush state machine, a ready flag and write backpressure.

Parameters:
- ENTRY_NUM, 512, total entries (power of 2).
- BANK_NUM, 4, banks; bank = index mod BANK_NUM (power of 2, ≤ ENTRY_NUM).
- READ_NUM, 4, fetch read lanes.
- WRITE_NUM, 2, update ports (≥1).
- QUEUE_DEPTH, 4, conflict-queue entries (≥ WRITE_NUM).
- TAG_WIDTH, 8, stored tag bits.
- TARGET_WIDTH, 12, stored low target bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  invalidate all entries and clear the queue
- rdPC  in  32  fetch PC of lane 0; lane i uses rdPC + 4*i
- rdHit  out  READ_NUM  per-lane hit
- rdTarget  out  READ_NUM*32  per-lane predicted target
- rdIsCondBr  out  READ_NUM  per-lane conditional-branch flag
- wrValid  in  WRITE_NUM  update request (valid && isApBCC)
- wrPC  in  WRITE_NUM*32  branch address
- wrTarget  in  WRITE_NUM*32  resolved next address
- wrIsCondBr  in  WRITE_NUM  conditional flag
- wrStall  out  1  upstream must hold new updates
- ready  out  1  init done, lookups valid
- queueCount  out  clog2(QUEUE_DEPTH+1)  occupied queue slots

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Address fields:
  - IDX = log2(ENTRY_NUM).
  - index = pc[IDX+1:2].
  - tag = pc[IDX+TAG_WIDTH+1:IDX+2].
  - Stored data = target[TARGET_WIDTH+1:2].
  - rdTarget = {lanePC[31:TARGET_WIDTH+2], stored, 2'b00}, using the registered lane PC.
- Entry format: {valid, tag, data, isCondBr}.
- FSM states INIT and RUN:
  - rst or flush forces INIT with initCnt=0, queue emptied and ready=0.
  - INIT clears one entry per bank per cycle (index initCnt*BANK_NUM+b) for ENTRY_NUM/BANK_NUM cycles, then enters RUN. With defaults this is 128 cycles.
  - A flush in INIT restarts initCnt. ready=1 only in RUN.
- Reset outputs: rdHit=0, rdTarget=0, rdIsCondBr=0, ready=0, wrStall=1, queueCount=0.
- In INIT:
  - rdHit is forced to 0.
  - wrValid is ignored (dropped).
  - wrStall=1.
- Read timing:
  - Read latency is 1 cycle: rdPC sampled at edge N gives outputs valid after edge N+1.
  - hit = ready && valid && tag match.
  - Reads never stall and have no read/write bypass. A write at edge N is visible to a read whose rdPC is sampled at edge N+1 or later.
- Write arbitration in RUN, each cycle, evaluated in port order 0..WRITE_NUM-1:
  - A port is diverted to the queue if any of the following holds:
    - its bank equals that of a lower-numbered direct write;
    - its index matches any valid queue entry;
    - its index matches a same-cycle lower-numbered diverted write (ordering).
  - Otherwise the port writes directly.
  - Up to WRITE_NUM diverted writes are pushed per cycle at tail, in port order.
  - Same index on two ports in one cycle: the higher port wins the final contents, because it is diverted behind the lower port.
- Queue drain:
  - Drain runs in the same cycle, oldest first, into idle write ports only.
  - The head entry pops if its bank conflicts with no direct write and no already-chosen drain this cycle.
  - Draining stops at the first head entry that cannot issue; there is no reordering.
  - Up to WRITE_NUM pops per cycle.
  - Entries pushed this cycle are not drainable until the next cycle.
- Backpressure:
  - wrStall = (queueCount > QUEUE_DEPTH - WRITE_NUM) or INIT. It is combinational from registered count and state.
  - A write presented while wrStall=1 is an upstream protocol violation. The block asserts (simulation) and drops it.
  - No accepted write is ever lost.
- queueCount = count + pushes - pops, updated each edge. Head and tail pointers wrap modulo QUEUE_DEPTH.
- Full and empty are distinguished by count. There is no pointer-equality ambiguity.

Test Plan:
- Init sequence: rst high for 1 cycle, then low → ready=0 and wrStall=1 for 128 cycles, ready=1 on cycle 129; read 0x1000 → rdHit=0.
- Basic hit and target reconstruction: write pc 0x1000 → target 0x1040, then read rdPC=0x1000 → rdHit=4'b0001, rdTarget[0]=0x1040, lane1–3 miss. Then read 0x3000 (same index, tag differs) → miss.
- Bank conflict: port0 pc 0x1000, port1 pc 0x1010 (both bank 0) → queueCount=1 next cycle, 0 the cycle after; reads of both hit with correct targets.
- Backpressure: every cycle send a bank-0 pair at new indices while the queue head is bank 0 → queueCount climbs 1/cycle, wrStall=1 once count=3; after release the queue drains to 0 and every written entry hits.
- Ordering: queued write 0x1010→0x2000, then next cycle direct-eligible write 0x1010→0x3000 → second is also queued; final read 0x1010 gives 0x3000.
- Flush mid-operation: flush with queueCount=2 → queueCount=0 next cycle, ready=0 for 128 cycles, all prior entries miss; a second flush at cycle 50 extends INIT to 128 cycles from that point.
